operand_sequencer: RTL

//  Parametrised successor to the single-pass BRAM operand controller. Walks a programmable

---
 rtl/opseq_pkg.sv | 11 +
 rtl/opseq_delay_line.sv | 15 +
 rtl/operand_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/opseq_pkg.sv
// opseq_pkg: FSM state encoding and pipeline tag field layout
package opseq_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  // tag = {addr, add_sub, valid}
  localparam int TAG_VLD = 0;
  localparam int TAG_SUB = 1;
  localparam int TAG_ADR = 2;
endpackage

// File: rtl/opseq_delay_line.sv
// opseq_delay_line: enabled tag shift register exposing every stage
module opseq_delay_line #(
  parameter int W = 6,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [W-1:0]              d,
  output logic [DEPTH-1:0][W-1:0]   q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= {q[DEPTH-2:0], d};
endmodule

// File: rtl/operand_sequencer.sv
// operand_sequencer: walks an operand BRAM window, feeds an adder, writes results back
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int BRAM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  start_stop,
  input  logic                  add_sub,
  input  logic                  loop_mode,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic [2*DATA_W-1:0]   douta,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic                  cin,
  output logic                  op_valid,
  input  logic [DATA_W-1:0]     sum,
  input  logic                  cout,
  output logic                  res_we,
  output logic [ADDR_W-1:0]     res_addr,
  output logic [DATA_W:0]       res_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       count
);
  localparam int TW = ADDR_W + 2;
  localparam int DEPTH = BRAM_LAT + 1;
  logic [1:0] state, state_nx;
  logic ss_q, start, issue, at_last, in_flight, res_we_q;
  logic [ADDR_W-1:0] base_q, last_q;
  logic [DEPTH-1:0][TW-1:0] tags;
  logic [TW-1:0] tap, fin;
  assign start = ena && state == IDLE && start_stop && !ss_q;
  assign issue = ena && state == RUN && start_stop;
  assign at_last = addr == last_q;
  assign tap = tags[BRAM_LAT-1];
  assign fin = tags[BRAM_LAT];
  assign op_valid = fin[TAG_VLD];
  // a registered result still counts as in flight until it is committed
  assign res_we = res_we_q && ena;
  always_comb begin
    in_flight = res_we_q;
    for (int i = 0; i < DEPTH; i++) in_flight |= tags[i][TAG_VLD];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ss_q <= 1'b0;
      base_q <= '0;
      last_q <= '0;
      addr <= '0;
      count <= '0;
    end else if (ena) begin
      state <= state_nx;
      ss_q <= start_stop;
      if (start) begin
        base_q <= base_addr;
        last_q <= last_addr;
        addr <= base_addr;
      end else if (issue) addr <= at_last ? base_q : addr + 1'b1;
      if (start) count <= '0;
      else if (res_we_q && ~&count) count <= count + 1'b1;
    end
  always_comb begin
    state_nx = state;
    if (ena)
      case (state)
        IDLE: state_nx = (start_stop && !ss_q) ? RUN : IDLE;
        RUN: state_nx = (!start_stop || (at_last && !loop_mode)) ? DRAIN : RUN;
        DRAIN: state_nx = in_flight ? DRAIN : DONE;
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  opseq_delay_line #(.W(TW), .DEPTH(DEPTH)) u_tags (
    .clk(clk),
    .rst(rst),
    .en(ena),
    .d({addr, add_sub, issue}),
    .q(tags)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      A <= '0;
      B <= '0;
      cin <= 1'b0;
    end else if (ena && tap[TAG_VLD]) begin
      A <= douta[2*DATA_W-1:DATA_W];
      B <= tap[TAG_SUB] ? ~douta[DATA_W-1:0] : douta[DATA_W-1:0];
      cin <= tap[TAG_SUB];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      res_we_q <= 1'b0;
      res_addr <= '0;
      res_data <= '0;
    end else if (ena) begin
      res_we_q <= op_valid;
      if (op_valid) begin
        res_addr <= fin[TAG_ADR +: ADDR_W];
        res_data <= {cout, sum};
      end
    end
endmodule
